// File: rtl/alu_bist_pkg.sv
// alu_bist_pkg -- shared definitions for the ALU built-in self-test.
//   * ALU opcode encodings and is_undefined_op()
//   * POLY: feedback mask shared by the operand LFSR and the signature MISR
//   * poly_step(): one left-shifting Galois step with POLY feedback
//   * state_t: BIST controller FSM states
package alu_bist_pkg;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_LT  = 4'd7;
  localparam logic [3:0] OP_SRL = 4'd8;
  localparam logic [3:0] OP_SLL = 4'd9;
  localparam logic [3:0] OP_SRA = 4'd10;
  localparam logic [3:0] OP_XOR = 4'd13;

  localparam logic [31:0] POLY = 32'h8020_0003;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_APPLY,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  function automatic logic is_undefined_op(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_LT,
      OP_SRL, OP_SLL, OP_SRA, OP_XOR: return 1'b0;
      default:                        return 1'b1;
    endcase
  endfunction

  // Bit 0 of POLY is set, so a nonzero state never collapses to zero.
  function automatic logic [31:0] poly_step(input logic [31:0] s);
    return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0);
  endfunction

endpackage

// File: rtl/alu_bist_if.sv
// alu_bist_if -- operand/result bus between the BIST controller and the ALU.
//   alu_op1, alu_op2 : 32-bit operands   (master -> slave)
//   alu_op           : 4-bit opcode      (master -> slave)
//   alu_result       : 32-bit result     (slave -> master)
//   alu_zero         : ALU zero flag     (slave -> master)
// master = BIST controller, slave = ALU under test.
interface alu_bist_if;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_zero;

  modport master (
    output alu_op1, alu_op2, alu_op,
    input  alu_result, alu_zero
  );

  modport slave (
    input  alu_op1, alu_op2, alu_op,
    output alu_result, alu_zero
  );
endinterface

// File: rtl/alu_bist_lfsr.sv
// alu_bist_lfsr -- seedable 32-bit Galois LFSR advancing two steps per cycle.
//   clk, rst : clock, synchronous active-high reset (loads SEED)
//   load     : reload SEED
//   advance  : move the state forward by two steps
//   step1    : state after one step (combinational from current state)
//   step2    : state after two steps (next state when advancing)
module alu_bist_lfsr
  import alu_bist_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        advance,
  output logic [31:0] step1,
  output logic [31:0] step2
);

  logic [31:0] lfsr_q;

  assign step1 = poly_step(lfsr_q);
  assign step2 = poly_step(step1);

  always_ff @(posedge clk) begin
    if (rst || load) begin
      lfsr_q <= SEED;
    end else if (advance) begin
      lfsr_q <= step2;
    end
  end

endmodule

// File: rtl/alu_bist.sv
// alu_bist -- built-in self-test controller for a 32-bit ALU.
// Walks opcodes 0..15, applying TESTS_PER_OP pseudo-random operand pairs to
// each defined opcode and UNDEF_TESTS pairs to each undefined one, and folds
// every result into a MISR. pass compares the final signature with
// EXPECTED_SIG.
//   clk, rst   : clock, synchronous active-high reset
//   start      : request a run (accepted in IDLE or DONE only)
//   busy       : high from LOAD through the last CAPTURE
//   done       : high after a run until the next start or rst
//   pass       : run result, valid while done=1
//   signature  : MISR contents
//   zero_err   : sticky zero-flag mismatch
//   alu        : operand/opcode out, result/zero in (alu_bist_if.master)
// Optional feature: define ALU_BIST_ZERO_CHECK_EN to check alu_zero against
// the result; otherwise alu_zero is ignored and zero_err stays 0.
module alu_bist
  import alu_bist_pkg::*;
#(
  parameter int unsigned TESTS_PER_OP = 16,
  parameter int unsigned UNDEF_TESTS  = 2,
  parameter logic [31:0] LFSR_SEED    = 32'h0000_0001,
  parameter logic [31:0] EXPECTED_SIG = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] signature,
  output logic        zero_err,
  alu_bist_if.master  alu
);

  localparam int unsigned MAX_TESTS = (TESTS_PER_OP > UNDEF_TESTS) ? TESTS_PER_OP : UNDEF_TESTS;
  localparam int unsigned VEC_W     = (MAX_TESTS > 1) ? $clog2(MAX_TESTS) : 1;
  localparam logic [VEC_W-1:0] LAST_DEF   = VEC_W'(TESTS_PER_OP - 1);
  localparam logic [VEC_W-1:0] LAST_UNDEF = VEC_W'(UNDEF_TESTS - 1);

  state_t           state;
  logic [3:0]       op_cnt;
  logic [VEC_W-1:0] vec_cnt;
  logic [31:0]      lfsr_step1;
  logic [31:0]      lfsr_step2;
  logic [31:0]      sig_next;
  logic             zerr_next;
  logic             vec_last;

  alu_bist_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (state == ST_LOAD),
    .advance (state == ST_APPLY),
    .step1   (lfsr_step1),
    .step2   (lfsr_step2)
  );

  assign sig_next = poly_step(signature) ^ alu.alu_result;
  assign vec_last = (vec_cnt == (is_undefined_op(op_cnt) ? LAST_UNDEF : LAST_DEF));

`ifdef ALU_BIST_ZERO_CHECK_EN
  assign zerr_next = zero_err | (alu.alu_zero != (alu.alu_result == 32'h0));
`else
  logic unused_zero;
  assign unused_zero = alu.alu_zero;
  assign zerr_next   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      signature   <= 32'h0;
      zero_err    <= 1'b0;
      alu.alu_op1 <= 32'h0;
      alu.alu_op2 <= 32'h0;
      alu.alu_op  <= 4'h0;
      op_cnt      <= 4'h0;
      vec_cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state <= ST_LOAD;
            busy  <= 1'b1;
            done  <= 1'b0;
            pass  <= 1'b0;
          end
        end
        ST_LOAD: begin
          signature <= 32'h0;
          zero_err  <= 1'b0;
          done      <= 1'b0;
          op_cnt    <= 4'h0;
          vec_cnt   <= '0;
          state     <= ST_APPLY;
        end
        ST_APPLY: begin
          alu.alu_op  <= op_cnt;
          alu.alu_op1 <= lfsr_step1;
          alu.alu_op2 <= lfsr_step2;
          state       <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          signature <= sig_next;
          zero_err  <= zerr_next;
          if (vec_last) begin
            vec_cnt <= '0;
            if (op_cnt == 4'hF) begin
              // Verdict uses the just-computed values so it lands with done.
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (sig_next == EXPECTED_SIG) && !zerr_next;
            end else begin
              op_cnt <= op_cnt + 4'd1;
              state  <= ST_APPLY;
            end
          end else begin
            vec_cnt <= vec_cnt + 1'b1;
            state   <= ST_APPLY;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_bist.md
ALU_BIST -- requirements
Module: alu_bist

Interface
REQ-001 Parameter TESTS_PER_OP, default 16, SHALL set the number of vectors applied to each defined alu_op.
REQ-002 Parameter UNDEF_TESTS, default 2, SHALL set the number of vectors applied to each undefined alu_op (3, 4, 5, 11, 12, 14, 15).
REQ-003 Parameter LFSR_SEED, default 32'h0000_0001, SHALL set the operand LFSR seed; it must be nonzero.
REQ-004 Parameter EXPECTED_SIG, default 32'h0000_0000, SHALL set the golden MISR signature.
REQ-005 clk  in  1  single clock; all logic is clocked on the rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  requests a self-test run.
REQ-008 busy  out  1  high while a run is in progress.
REQ-009 done  out  1  high after a run completes; held until the next start or rst.
REQ-010 pass  out  1  result of the run; valid only while done=1.
REQ-011 signature  out  32  MISR contents.
REQ-012 zero_err  out  1  sticky flag: zero-flag mismatch detected.
REQ-013 alu_op1 and alu_op2  out  32 each  registered operands driven to the ALU.
REQ-014 alu_op  out  4  registered opcode driven to the ALU.
REQ-015 alu_result  in  32  ALU result.
REQ-016 alu_zero  in  1  ALU zero flag.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD, APPLY, CAPTURE and DONE.
REQ-018 In IDLE or DONE, start=1 SHALL move the FSM to LOAD; in any other state, start SHALL be ignored.
REQ-019 LOAD (1 cycle) SHALL set the LFSR to LOAD_SEED, clear signature, zero_err and done, and set the op counter and vector counter to 0.
REQ-020 APPLY (1 cycle) SHALL register alu_op=op counter, alu_op1=LFSR step1 and alu_op2=LFSR step2, and advance the LFSR by two steps.
REQ-021 CAPTURE (1 cycle) SHALL update the MISR with alu_result from the operands registered in the preceding APPLY.
REQ-022 The MISR update SHALL be sig_next = ({sig[30:0],1'b0} ^ (sig[31] ? 32'h8020_0003 : 0)) ^ alu_result.
REQ-023 The LFSR SHALL be a 32-bit Galois LFSR using the same polynomial mask 32'h8020_0003.
REQ-024 From CAPTURE, the FSM SHALL return to APPLY unless the last vector of op 15 has completed, in which case it SHALL go to DONE.
REQ-025 When the vector counter reaches the per-op limit, it SHALL reset to 0 and the op counter SHALL increment; ops are applied in the order 0..15 with no wrap.
REQ-026 With the default parameters, a run SHALL have 9×16 + 7×2 = 158 vectors; busy SHALL stay high for exactly 1 + 316 = 317 cycles (LOAD through the last CAPTURE), and done SHALL rise on the next cycle.
REQ-027 In DONE, pass SHALL equal (signature == EXPECTED_SIG) && !zero_err.
REQ-028 Operands and alu_op SHALL hold their last values in DONE.
REQ-029 start held high through a run SHALL produce one run only, then a re-run from DONE; the bench SHALL pulse start.
REQ-030 All counter widths SHALL be sized for the maximum of TESTS_PER_OP and UNDEF_TESTS with no overflow; a limit of 0 is illegal.

Reset
REQ-031 rst SHALL be synchronous and active-high, and SHALL take priority over start in the same cycle.
REQ-032 On reset, the FSM SHALL go to IDLE; busy, done, pass and zero_err SHALL be 0; signature, alu_op1, alu_op2 and alu_op SHALL be 0; the LFSR SHALL be set to LFSR_SEED.
REQ-033 rst asserted mid-run SHALL abort the run; the next cycle SHALL show the reset values, and no partial result SHALL be retained.

Configuration
REQ-034 With macro ALU_BIST_ZERO_CHECK_EN defined, CAPTURE SHALL set zero_err when alu_zero != (alu_result == 0).
REQ-035 With ALU_BIST_ZERO_CHECK_EN undefined, alu_zero SHALL be unused, zero_err SHALL be tied to 0, and pass SHALL depend on the signature only.

Structure
REQ-036 A shared package alu_bist_pkg SHALL hold the ALU opcode localparams (AND 0, OR 1, ADD 2, SUB 6, LT 7, SRL 8, SLL 9, SRA 10, XOR 13), an is_undefined_op function, the LFSR/MISR polynomial constant, and the FSM state enum.
REQ-037 The design SHALL include one sub-module, alu_bist_lfsr, which provides a seedable 32-bit Galois LFSR with two-step-per-cycle advance and outputs for both intermediate states.

Verification
REQ-038 After rst, with no start for 20 cycles, the bench SHALL check busy=0, done=0, alu_op=0 and operands=0.
REQ-039 A 1-cycle start pulse with the real alu attached and EXPECTED_SIG set to the reference-model signature SHALL give busy high for exactly 317 cycles, then done=1 and pass=1; the op sequence SHALL be 0×16, 1×16, 2×16, 3×2, and so on.
REQ-040 With alu_result bit 0 forced to 1 during op 2 (ADD), the run SHALL end with done=1, pass=0 and signature != EXPECTED_SIG.
REQ-041 With alu_zero tied to 0 and op 0 (AND) driven with op2 = 0, the bench SHALL check zero_err=1 and pass=0 with ALU_BIST_ZERO_CHECK_EN, and zero_err=0 and pass=1 without it.
REQ-042 rst asserted at busy cycle 100 SHALL give busy=0 and signature=0 on the next cycle; a new start SHALL then reproduce the signature of a clean run bit-exactly.
REQ-043 A start pulse at busy cycle 50 SHALL be ignored (same cycle count and signature as a clean run); a start pulse in DONE SHALL launch a second run with an identical signature.
